// File: rtl/ir_nec_rx.sv
// NEC infrared receiver: pulse-width decoder plus a 4-register slave (DATA, STATUS, CONTROL, RAW).
// Define IR_NEC_RX_REPEAT_EN to decode NEC repeat codes into STATUS.repeat (bit 2).
module ir_nec_rx #(
    parameter int TICK_DIV   = 50,
    parameter int TIME_SHIFT = 0    // divides every pulse window by 2**TIME_SHIFT; 0 gives real NEC timing
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        in_port,
    output logic [31:0] readdata,
    output logic        irq
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0] WIDTH_MAX = 14'h3FFF;

    localparam logic [13:0] LM_MIN  = 14'(8000 >> TIME_SHIFT);
    localparam logic [13:0] LM_MAX  = 14'(10000 >> TIME_SHIFT);
    localparam logic [13:0] LS_MIN  = 14'(4000 >> TIME_SHIFT);
    localparam logic [13:0] LS_MAX  = 14'(5000 >> TIME_SHIFT);
    localparam logic [13:0] SH_MIN  = 14'(400 >> TIME_SHIFT);
    localparam logic [13:0] SH_MAX  = 14'(700 >> TIME_SHIFT);
    localparam logic [13:0] ONE_MIN = 14'(1500 >> TIME_SHIFT);
    localparam logic [13:0] ONE_MAX = 14'(1900 >> TIME_SHIFT);
    localparam logic [13:0] TIMEOUT = 14'(12000 >> TIME_SHIFT);
`ifdef IR_NEC_RX_REPEAT_EN
    localparam logic [13:0] RS_MIN  = 14'(2000 >> TIME_SHIFT);
    localparam logic [13:0] RS_MAX  = 14'(2500 >> TIME_SHIFT);
`endif

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } state_t;

    function automatic logic in_win(input logic [13:0] w, input logic [13:0] lo,
                                    input logic [13:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    logic          sync0_q, sync0_d;
    logic          sync1_q, sync1_d;
    logic          prev_q, prev_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [13:0]   width_q, width_d;
    state_t        state_q, state_d;
    logic [31:0]   shift_q, shift_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          rep_q, rep_d;
    logic          en_q, en_d;
    logic          irq_en_q, irq_en_d;
    logic [31:0]   readdata_q, readdata_d;
`ifdef IR_NEC_RX_REPEAT_EN
    logic          rpt_path_q, rpt_path_d;
`endif

    logic tick;
    logic fall_edge;
    logic rise_edge;
    logic frame_done;
    logic rpt_done;
    logic status_wr;
    logic control_wr;
    logic unused_bits;

    assign unused_bits = ^writedata[31:2];

    assign tick       = (presc_q == PRESC_LAST);
    assign fall_edge  = prev_q & ~sync1_q;
    assign rise_edge  = ~prev_q & sync1_q;
    assign status_wr  = chipselect & write & (address == 2'd1);
    assign control_wr = chipselect & write & (address == 2'd2);

    always_comb begin
        sync0_d    = in_port;
        sync1_d    = sync0_q;
        prev_d     = sync1_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        width_d    = width_q;
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        frame_done = 1'b0;
        rpt_done   = 1'b0;
`ifdef IR_NEC_RX_REPEAT_EN
        rpt_path_d = rpt_path_q;
`endif

        if (fall_edge || rise_edge) begin
            width_d = '0;
        end else if (tick && (width_q != WIDTH_MAX)) begin
            width_d = width_q + 14'd1;
        end

        // Every decision is taken at a line edge using the width of the level that just ended.
        case (state_q)
            IDLE: begin
                if (fall_edge) state_d = LEAD_MARK;
            end
            LEAD_MARK: begin
                if (rise_edge) state_d = in_win(width_q, LM_MIN, LM_MAX) ? LEAD_SPACE : IDLE;
            end
            LEAD_SPACE: begin
                if (fall_edge) begin
                    state_d = IDLE;
                    if (in_win(width_q, LS_MIN, LS_MAX)) begin
                        state_d   = BIT_MARK;
                        bit_cnt_d = '0;
`ifdef IR_NEC_RX_REPEAT_EN
                        rpt_path_d = 1'b0;
                    end else if (in_win(width_q, RS_MIN, RS_MAX)) begin
                        state_d    = STOP_MARK;
                        rpt_path_d = 1'b1;
`endif
                    end
                end
            end
            BIT_MARK: begin
                if (rise_edge) state_d = in_win(width_q, SH_MIN, SH_MAX) ? BIT_SPACE : IDLE;
            end
            BIT_SPACE: begin
                if (fall_edge) begin
                    if (in_win(width_q, SH_MIN, SH_MAX) || in_win(width_q, ONE_MIN, ONE_MAX)) begin
                        shift_d   = {in_win(width_q, ONE_MIN, ONE_MAX), shift_q[31:1]};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        state_d   = (bit_cnt_q == 5'd31) ? STOP_MARK : BIT_MARK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            STOP_MARK: begin
                if (rise_edge) begin
                    state_d = IDLE;
                    if (in_win(width_q, SH_MIN, SH_MAX)) begin
`ifdef IR_NEC_RX_REPEAT_EN
                        rpt_done   = rpt_path_q;
                        frame_done = ~rpt_path_q;
`else
                        frame_done = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && (width_q >= TIMEOUT)) state_d = IDLE;
        if (!en_q) state_d = IDLE;
    end

    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        rep_d      = rep_q;
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        readdata_d = readdata_q;

        // Clears are applied first so a same-cycle hardware set takes priority.
        if (status_wr) begin
            if (writedata[0]) valid_d   = 1'b0;
            if (writedata[1]) overrun_d = 1'b0;
`ifdef IR_NEC_RX_REPEAT_EN
            if (writedata[2]) rep_d     = 1'b0;
`endif
        end
        if (frame_done) begin
            if (valid_q) begin
                overrun_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end
        if (rpt_done) rep_d = 1'b1;

        if (control_wr) begin
            en_d     = writedata[0];
            irq_en_d = writedata[1];
        end

        if (chipselect && read) begin
            case (address)
                2'd0:    readdata_d = data_q;
                2'd1:    readdata_d = {29'd0, rep_q, overrun_q, valid_q};
                2'd2:    readdata_d = {30'd0, irq_en_q, en_q};
                default: readdata_d = {31'd0, sync1_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_q    <= 1'b1;
            sync1_q    <= 1'b1;
            prev_q     <= 1'b1;
            presc_q    <= '0;
            width_q    <= '0;
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            rep_q      <= 1'b0;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            readdata_q <= '0;
`ifdef IR_NEC_RX_REPEAT_EN
            rpt_path_q <= 1'b0;
`endif
        end else begin
            sync0_q    <= sync0_d;
            sync1_q    <= sync1_d;
            prev_q     <= prev_d;
            presc_q    <= presc_d;
            width_q    <= width_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            rep_q      <= rep_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            readdata_q <= readdata_d;
`ifdef IR_NEC_RX_REPEAT_EN
            rpt_path_q <= rpt_path_d;
`endif
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_en_q & (valid_q | overrun_q | rep_q);

endmodule
